// File: rtl/nibble_stream_scheduler_if.sv
// Request, serialiser and detector signals shared between the nibble stream
// scheduler (slave) and the requester/detector side (master).
interface nibble_stream_scheduler_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [4*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 flush;
    logic [3:0]           bit_stream;
    logic                 p2s_load;
    logic                 data_valid;
    logic [1:0]           owner;
    logic                 busy;
    logic                 moore_detected;
    logic                 mealy_detected;
    logic [NUM_REQ-1:0]   moore_hit;
    logic [NUM_REQ-1:0]   mealy_hit;

    modport master (
        output req_valid, req_data, flush, moore_detected, mealy_detected,
        input  req_ready, bit_stream, p2s_load, data_valid, owner, busy,
               moore_hit, mealy_hit
    );

    modport slave (
        input  req_valid, req_data, flush, moore_detected, mealy_detected,
        output req_ready, bit_stream, p2s_load, data_valid, owner, busy,
               moore_hit, mealy_hit
    );
endinterface

// File: rtl/nibble_stream_scheduler.sv
// Round-robin scheduler sharing one serialiser/detector pair among NUM_REQ
// nibble requesters, and routing detector pulses back to the owning requester.
module nibble_stream_scheduler #(
    parameter int NUM_REQ    = 2,
    parameter int GAP_CYCLES = 0,
    parameter int DET_LAT    = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    nibble_stream_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  rr_ptr;
    logic [2:0]  cnt;
    logic [3:0]  nibble_q;
    logic [1:0]  owner_q;

    logic [3:0]  valid_pad;
    logic [15:0] data_pad;
    logic        grant_found;
    logic [1:0]  grant_idx;
    logic        grant_en;
    logic        shift_active;

    logic [DET_LAT-1:0] pipe_valid;
    logic [1:0]         pipe_owner [DET_LAT];

    // Requester index arithmetic modulo NUM_REQ; base and off are both below NUM_REQ.
    function automatic logic [1:0] wrap_add(input logic [1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return 2'(sum);
    endfunction

    // Zero-extended to the 4-requester maximum so a 2-bit index is always legal.
    assign valid_pad = 4'(bus.req_valid);
    assign data_pad  = 16'(bus.req_data);

    // NOTE: every always_comb output gets a default before any conditional
    //       assignment, so no path can leave it holding its old value (a latch).
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!grant_found && valid_pad[wrap_add(rr_ptr, off)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_add(rr_ptr, off);
            end
        end
    end

    // Reset gates the grant so no transfer can be taken while reset_n is low.
    assign grant_en = (state == IDLE) && reset_n && !bus.flush && grant_found;

    always_comb begin
        bus.req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            bus.req_ready[k] = grant_en && (grant_idx == 2'(k));
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (grant_en) state_next = SHIFT;
            SHIFT:   if (cnt == 3'd3) state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
            GAP:     if (cnt == 3'(GAP_CYCLES - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.flush && (state != IDLE)) state_next = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    //       register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            rr_ptr   <= 2'd0;
            cnt      <= 3'd0;
            nibble_q <= 4'd0;
            owner_q  <= 2'd0;
        end else begin
            state <= state_next;
            cnt   <= ((state_next == state) && (state != IDLE)) ? cnt + 3'd1 : 3'd0;
            if (grant_en) begin
                nibble_q <= data_pad[{grant_idx, 2'b00} +: 4];
                owner_q  <= grant_idx;
                rr_ptr   <= wrap_add(grant_idx, 1);
            end
        end
    end

    assign shift_active   = (state == SHIFT);
    assign bus.data_valid = shift_active;
    assign bus.p2s_load   = shift_active && (cnt == 3'd0);
    assign bus.busy       = (state != IDLE);
    assign bus.bit_stream = nibble_q;
    assign bus.owner      = owner_q;

    // Attribution pipeline deliberately ignores flush: bits already sent still
    // belong to their requester when the detector answers.
    // NOTE: this small delay line is reset like any other state so stale owners
    //       cannot be credited with hits right after reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pipe_valid <= '0;
            for (int i = 0; i < DET_LAT; i++) pipe_owner[i] <= 2'd0;
        end else begin
            pipe_valid[0] <= shift_active;
            pipe_owner[0] <= owner_q;
            for (int i = 1; i < DET_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_owner[i] <= pipe_owner[i-1];
            end
        end
    end

    always_comb begin
        bus.moore_hit = '0;
        bus.mealy_hit = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            bus.moore_hit[k] = bus.moore_detected && pipe_valid[DET_LAT-1]
                               && (pipe_owner[DET_LAT-1] == 2'(k));
            bus.mealy_hit[k] = bus.mealy_detected && pipe_valid[DET_LAT-1]
                               && (pipe_owner[DET_LAT-1] == 2'(k));
        end
    end

    a_ready_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(bus.req_ready));
    a_valid_busy: assert property (@(posedge clk) disable iff (!reset_n)
        bus.data_valid |-> bus.busy);

endmodule

// File: doc/nibble_stream_scheduler.md
Name: nibble_stream_scheduler

Overview:
Round-robin scheduler that shares one parallel-to-serial + sequence-detector datapath among NUM_REQ nibble requesters. Accepts 4-bit nibbles over valid/ready handshakes and presents each nibble on bit_stream with a load strobe. Asserts data_valid for exactly the 4 serialisation cycles of each nibble. Attributes the returning moore/mealy detection pulses to the requester whose bits produced them. Sits directly in front of the serialiser/detector pair at top level.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
GAP_CYCLES, 0, idle cycles inserted after each nibble (0..7)
DET_LAT, 1, cycles from a bit's data_valid cycle to its detector output (1..3)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  reset, synchronous, active-low
req_valid  in  NUM_REQ  requester i holds a nibble
req_data  in  4*NUM_REQ  nibble of requester i on [4i+3:4i]
req_ready  out  NUM_REQ  accept; transfer when valid&ready; at most one bit high
flush  in  1  synchronous abort of current nibble
bit_stream  out  4  nibble to serialiser, stable while data_valid=1
p2s_load  out  1  one-cycle strobe, first cycle of each nibble
data_valid  out  1  high for the 4 serial bit cycles of a nibble
owner  out  2  index of requester owning bit_stream
busy  out  1  state != IDLE
moore_detected  in  1  detector output (Moore)
mealy_detected  in  1  detector output (Mealy)
moore_hit  out  NUM_REQ  one-cycle pulse on owning requester's bit
mealy_hit  out  NUM_REQ  one-cycle pulse on owning requester's bit

Behaviour:
- Reset (reset_n=0 at edge): state IDLE, rr pointer 0, bit_stream 0, owner 0, p2s_load 0, data_valid 0, busy 0, hit outputs 0, owner/valid delay pipeline cleared. req_ready is 0 during reset. Mid-nibble reset aborts the nibble with no further data_valid.
- FSM states IDLE, SHIFT, GAP.
- IDLE: req_ready is combinational. The grant goes to the first i with req_valid[i]=1, searching from the rr pointer upward with wrap. No grant if flush=1 or no valid. On a transfer at edge T: bit_stream<=req_data[g], owner<=g, pointer<=(g+1) mod NUM_REQ, bit counter<=0, state<=SHIFT.
- SHIFT: data_valid=1 for 4 cycles, counter 0..3. p2s_load=1 only at counter 0. bit_stream/owner held. After counter 3: GAP if GAP_CYCLES>0, else IDLE.
- GAP: data_valid=0 for GAP_CYCLES cycles, then IDLE.
- Throughput: one nibble per 5+GAP_CYCLES cycles; the IDLE grant cycle is mandatory.
- flush=1 in SHIFT or GAP: state<=IDLE at that edge. data_valid and p2s_load are 0 from the next cycle. The pointer is unchanged and the nibble is dropped. reset_n has priority over flush.
- Attribution: a DET_LAT-deep pipeline of {data_valid, owner}.
  - moore_hit[k]=1 when moore_detected=1 and the delayed valid=1 and the delayed owner=k; same rule for mealy.
  - Detector pulses while the delayed valid=0 are ignored.
  - The pipeline keeps running through flush, so in-flight bits are still attributed.
- Hit outputs are combinational from the registered pipeline and the detector inputs.
- An unused owner MSB is tied 0 when NUM_REQ=2.

Test Plan:
- Reset: reset_n=0 for 2 cycles, all req_valid=1 -> req_ready=0, data_valid=0, busy=0. First grant after release goes to requester 0.
- Single request: req0 valid with 4'b1011 in IDLE -> req_ready[0]=1 that cycle. Next 4 cycles: bit_stream=4'b1011, data_valid=1, p2s_load=1 only in the first, owner=0. Then 1 IDLE cycle.
- Round robin: NUM_REQ=3, all valid continuously -> grant order 0,1,2,0, a new nibble every 5 cycles. With GAP_CYCLES=2, every 7 cycles.
- Flush: flush=1 in SHIFT counter 1 -> data_valid=0 from the next cycle, state IDLE. The next grant follows the pointer (requester 1 after owner 0).
- Attribution: DET_LAT=1, owner=1. moore_detected=1 the cycle after the 4th data_valid -> moore_hit=2'b10. moore_detected=1 during IDLE with no delayed valid -> moore_hit=0.
- Boundary: flush and reset_n=0 in the same cycle -> reset values. Requester drops valid while another is valid at the pointer -> grant skips to the valid one.
